// File: rtl/fpu_norm_round.sv
// fpu_norm_round
//   Normalise/round stage that sits after the FPU add/sub datapath.
//   It takes an unnormalised mantissa with carry, hidden, fraction and round bits,
//   plus the upstream sticky bit. It normalises the mantissa one shift per clock,
//   rounds to nearest-even and emits the packed result with a one-cycle done pulse.
//   Packed format: [31] sign, [30:26] exponent (bias 15), [25:0] fraction, hidden 1.
//   Exponent 0 encodes zero (there are no subnormals); exponent 31 encodes infinity.
//
// Handshake: start_in is a one-sided valid with no ready.
//   It is sampled only while the FSM is in IDLE; while busy_out is high it is ignored.
//   done_out is a one-cycle valid for data_out/status_out, and those hold until the next done.
//
// Ports
//   clock100KHz  system clock, rising edge
//   reset        synchronous, active-low
//   start_in     operand valid (IDLE only)
//   sign_in      result sign
//   exp_in       unnormalised exponent
//   raw_mant_in  [28] carry, [27] hidden, [26:1] fraction, [0] round bit
//   sticky_in    OR of bits shifted out upstream
//   busy_out     high in NORM and ROUND
//   done_out     one-cycle result strobe
//   data_out     packed result
//   status_out   one-hot {UNDERFLOW, OVERFLOW, INEXACT, EXACT}
//   state_dbg    current FSM state encoding, for observation only
module fpu_norm_round #(
  parameter int EXP_W   = 5,
  parameter int MAN_W   = 26,
  parameter int EXP_MAX = 30
) (
  input  logic               clock100KHz,
  input  logic               reset,
  input  logic               start_in,
  input  logic               sign_in,
  input  logic [EXP_W-1:0]   exp_in,
  input  logic [MAN_W+2:0]   raw_mant_in,
  input  logic               sticky_in,
  output logic               busy_out,
  output logic               done_out,
  output logic [31:0]        data_out,
  output logic [3:0]         status_out,
  output logic [1:0]         state_dbg
);

  localparam int MW = MAN_W + 3;   // carry + hidden + fraction + round
  localparam int EW = EXP_W + 1;   // one guard bit so increments/decrements never wrap silently

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [MW-1:0]   mant, mant_n;
  logic [EW-1:0]   exp_q, exp_n;
  logic            sticky, sticky_n;
  logic            sign_q, sign_n;
  logic            ovf_q, ovf_n;
  logic            unf_q, unf_n;
  logic            zero_q, zero_n;
  logic            done_n;
  logic [31:0]     data_n;
  logic [3:0]      status_n;

  // Rounding terms, only consumed in ROUND.
  logic            inc;
  logic [MW-1:0]   rnd;
  logic            carry;
  logic [EW-1:0]   exp_r;
  logic [MAN_W-1:0] frac_r;
  logic            inexact;

  // Round-to-nearest-even: increment at bit1 when the round bit is set and
  // either something below it was lost or the kept LSB is odd.
  assign inc     = mant[0] & (sticky | mant[1]);
  assign rnd     = mant + {{(MW-2){1'b0}}, inc, 1'b0};
  assign carry   = rnd[MW-1];
  assign exp_r   = exp_q + {{EXP_W{1'b0}}, carry};
  // A carry out of the hidden bit means the mantissa became exactly 2.0.
  assign frac_r  = carry ? '0 : rnd[MAN_W:1];
  assign inexact = mant[0] | sticky;

  assign busy_out  = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clock100KHz) begin
    if (!reset) begin
      state      <= IDLE;
      mant       <= '0;
      exp_q      <= '0;
      sticky     <= 1'b0;
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      zero_q     <= 1'b0;
      done_out   <= 1'b0;
      data_out   <= '0;
      status_out <= '0;
    end else begin
      state      <= state_n;
      mant       <= mant_n;
      exp_q      <= exp_n;
      sticky     <= sticky_n;
      sign_q     <= sign_n;
      ovf_q      <= ovf_n;
      unf_q      <= unf_n;
      zero_q     <= zero_n;
      done_out   <= done_n;
      data_out   <= data_n;
      status_out <= status_n;
    end
  end

  always_comb begin
    state_n  = state;
    mant_n   = mant;
    exp_n    = exp_q;
    sticky_n = sticky;
    sign_n   = sign_q;
    ovf_n    = ovf_q;
    unf_n    = unf_q;
    zero_n   = zero_q;
    done_n   = 1'b0;
    data_n   = data_out;
    status_n = status_out;

    case (state)
      IDLE: begin
        if (start_in) begin
          mant_n   = raw_mant_in;
          exp_n    = {1'b0, exp_in};
          sticky_n = sticky_in;
          sign_n   = sign_in;
          ovf_n    = 1'b0;
          unf_n    = 1'b0;
          zero_n   = 1'b0;
          state_n  = NORM;
        end
      end

      NORM: begin
        if (mant == '0) begin
          zero_n  = 1'b1;
          state_n = ROUND;
        end else if (mant[MW-1]) begin
          mant_n   = mant >> 1;
          sticky_n = sticky | mant[0];
          exp_n    = exp_q + 1'b1;
          if (exp_q >= EW'(EXP_MAX)) begin
            ovf_n   = 1'b1;
            state_n = ROUND;
          end
        end else if (!mant[MW-2]) begin
          mant_n = mant << 1;
          exp_n  = exp_q - 1'b1;
          // Decrementing from 1 would land on the zero encoding.
          if (exp_q <= EW'(1)) begin
            unf_n   = 1'b1;
            state_n = ROUND;
          end
        end else begin
          state_n = ROUND;
        end
      end

      ROUND: begin
        done_n  = 1'b1;
        state_n = IDLE;
        if (ovf_q) begin
          data_n   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          status_n = 4'b0100;
        end else if (unf_q) begin
          data_n   = {sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
          status_n = 4'b1000;
        end else if (zero_q) begin
          data_n   = {sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
          status_n = 4'b0001;
        end else if (exp_r > EW'(EXP_MAX)) begin
          data_n   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          status_n = 4'b0100;
        end else begin
          data_n   = {sign_q, exp_r[EXP_W-1:0], frac_r};
          status_n = inexact ? 4'b0010 : 4'b0001;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fpu_norm_round.sv
// tb_fpu_norm_round
//   Directed-vector bench for fpu_norm_round. A numeric model derives the result,
//   the status and the latency of each operation from the number format. A compare
//   process checks every done pulse against the expected queue.
module tb_fpu_norm_round;

  logic        clk;
  logic        reset;
  logic        start_in;
  logic        sign_in;
  logic [4:0]  exp_in;
  logic [28:0] raw_mant_in;
  logic        sticky_in;
  logic        busy_out;
  logic        done_out;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] exp_q[$];
  logic [3:0]  stat_q[$];
  int          lat_q[$];
  int          start_q[$];

  fpu_norm_round dut (
    .clock100KHz (clk),
    .reset       (reset),
    .start_in    (start_in),
    .sign_in     (sign_in),
    .exp_in      (exp_in),
    .raw_mant_in (raw_mant_in),
    .sticky_in   (sticky_in),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .data_out    (data_out),
    .status_out  (status_out),
    .state_dbg   (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Numeric model: find the leading one, work out how far it must move,
  // then round the 27-bit significand to nearest-even.
  function automatic void model(input logic sg, input logic [4:0] ex,
                                input logic [28:0] raw, input logic st,
                                output logic [31:0] d, output logic [3:0] s,
                                output int lat);
    int          e, p, n, lim, v;
    logic [28:0] m;
    logic        sk, ovf, unf, zer, inc;
    logic [26:0] hf;
    e = int'(ex); m = raw; sk = st; ovf = 0; unf = 0; zer = 0; lat = 0;
    if (raw == 29'd0) begin
      zer = 1; lat = 2;
    end else if (raw[28]) begin
      if (ex >= 5'd30) begin ovf = 1; lat = 2; end
      else begin sk = st | raw[0]; m = raw >> 1; e = e + 1; lat = 3; end
    end else begin
      p = 0;
      for (int i = 0; i < 28; i++) if (raw[i]) p = i;
      n = 27 - p;
      lim = (e < 1) ? 1 : e;
      if (n > 0 && n >= lim) begin unf = 1; lat = lim + 1; end
      else begin m = raw << n; e = e - n; lat = n + 2; end
    end
    hf  = m[27:1];
    inc = m[0] & (sk | m[1]);
    v   = int'(hf) + int'(inc);
    if (v == (1 << 27)) begin e = e + 1; v = 0; end
    if (ovf)           begin d = {sg, 5'h1F, 26'd0}; s = 4'b0100; end
    else if (unf)      begin d = {sg, 31'd0};        s = 4'b1000; end
    else if (zer)      begin d = {sg, 31'd0};        s = 4'b0001; end
    else if (e > 30)   begin d = {sg, 5'h1F, 26'd0}; s = 4'b0100; end
    else begin
      d = {sg, e[4:0], v[25:0]};
      s = (m[0] | sk) ? 4'b0010 : 4'b0001;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // scoreboard compare process
  always @(negedge clk) begin
    if (reset && done_out) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        check("data",    data_out,             exp_q.pop_front());
        check("status",  {28'd0, status_out},  {28'd0, stat_q.pop_front()});
        check("latency", cyc - start_q.pop_front(), lat_q.pop_front());
        check("onehot",  {31'd0, $onehot(status_out)}, 32'd1);
      end
    end
  end

  // driver tasks
  task automatic send(input logic sg, input logic [4:0] ex, input logic [28:0] raw, input logic st);
    logic [31:0] d; logic [3:0] s; int lat;
    model(sg, ex, raw, st, d, s, lat);
    exp_q.push_back(d); stat_q.push_back(s); lat_q.push_back(lat);
    start_in = 1'b1; sign_in = sg; exp_in = ex; raw_mant_in = raw; sticky_in = st;
    @(posedge clk); #1;
    start_q.push_back(cyc);
    start_in = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done_out && n < 60);
    checks++;
    if (!done_out) begin
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end
  endtask

  task automatic pin(input string name, input logic sg, input logic [4:0] ex,
                     input logic [28:0] raw, input logic st,
                     input logic [31:0] rd, input logic [3:0] rs, input int rl);
    logic [31:0] d; logic [3:0] s; int lat;
    model(sg, ex, raw, st, d, s, lat);
    check({name, "_data"}, d, rd);
    check({name, "_stat"}, {28'd0, s}, {28'd0, rs});
    check({name, "_lat"},  lat, rl);
  endtask

  typedef struct { logic sg; logic [4:0] ex; logic [28:0] raw; logic st; } vec_t;
  vec_t vecs[$];

  initial begin
    reset = 1'b0; start_in = 1'b0; sign_in = 1'b0; exp_in = '0; raw_mant_in = '0; sticky_in = 1'b0;

    // Model pinned against hand-computed values.
    pin("pin_hidden", 0, 5'd15, 29'h0800_0000, 0, 32'h3C00_0000, 4'b0001, 2);
    pin("pin_left2",  0, 5'd15, 29'h0200_0000, 0, 32'h3400_0000, 4'b0001, 4);
    pin("pin_tie",    0, 5'd15, 29'h0800_0003, 0, 32'h3C00_0002, 4'b0010, 2);
    pin("pin_ovf",    0, 5'd30, 29'h1000_0000, 0, 32'h7C00_0000, 4'b0100, 2);
    pin("pin_unf",    1, 5'd1,  29'h0400_0000, 0, 32'h8000_0000, 4'b1000, 2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   {31'd0, busy_out}, 32'd0);
    check("rst_done",   {31'd0, done_out}, 32'd0);
    check("rst_data",   data_out,          32'd0);
    check("rst_status", {28'd0, status_out}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    vecs = '{
      '{0, 5'd15, 29'h0800_0000, 0},   // already normal
      '{0, 5'd15, 29'h1000_0000, 0},   // carry: one right shift
      '{0, 5'd15, 29'h0200_0000, 0},   // two left shifts
      '{0, 5'd15, 29'h0800_0003, 0},   // tie, odd LSB -> round up
      '{0, 5'd15, 29'h0800_0001, 0},   // tie, even LSB -> stays
      '{0, 5'd15, 29'h0800_0000, 1},   // only sticky -> inexact
      '{0, 5'd30, 29'h1000_0000, 0},   // overflow on right shift
      '{1, 5'd1,  29'h0400_0000, 0},   // underflow on left shift
      '{1, 5'd7,  29'h0000_0000, 0},   // zero
      '{0, 5'd15, 29'h0FFF_FFFF, 0},   // round carry into exponent
      '{0, 5'd30, 29'h0FFF_FFFF, 0},   // round carry overflows
      '{0, 5'd10, 29'h1000_0001, 0},   // right shift feeds sticky
      '{0, 5'd29, 29'h0000_0001, 0},   // longest shift, k = 27
      '{1, 5'd3,  29'h0010_0000, 1},   // underflow after several shifts
      '{1, 5'd20, 29'h0AAA_AAAB, 1}    // round up with sticky
    };
    // Each new start is driven in the done cycle of the previous operation.
    foreach (vecs[i]) begin
      send(vecs[i].sg, vecs[i].ex, vecs[i].raw, vecs[i].st);
      wait_done();
    end

    // start_in held while busy must be ignored.
    send(0, 5'd28, 29'h0000_0002, 0);
    start_in = 1'b1; exp_in = 5'd3; raw_mant_in = 29'h1000_0000;
    repeat (4) @(negedge clk);
    start_in = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    // Reset during NORM aborts with no done pulse.
    send(0, 5'd20, 29'h0000_0004, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_busy",   {31'd0, busy_out}, 32'd0);
    check("abort_done",   {31'd0, done_out}, 32'd0);
    check("abort_data",   data_out,          32'd0);
    check("abort_status", {28'd0, status_out}, 32'd0);
    void'(exp_q.pop_back()); void'(stat_q.pop_back());
    void'(lat_q.pop_back()); void'(start_q.pop_back());
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_idle", {31'd0, busy_out}, 32'd0);

    // Back-to-back after the abort.
    send(0, 5'd15, 29'h0200_0000, 0);
    wait_done();
    send(1, 5'd15, 29'h1000_0000, 0);
    wait_done();
    repeat (3) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
